// File: rtl/iterative_alu_unit.sv
// Execute-stage ALU: single-cycle logic/add/sub/slt, iterative shift-add MUL and
// (when ALU_DIV_EN is defined) restoring DIVU/REMU, with a start/done handshake.
module iterative_alu_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic [1:0]       fsm_state
);

  // Handshake: start is sampled only in IDLE; busy is high whenever the unit is
  // not IDLE; done is a one-cycle pulse and result/zero hold until the next done.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
`ifdef ALU_DIV_EN
  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam logic [3:0] OP_REMU = 4'b1010;
`endif

  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] opa_q;   // MUL: shifting multiplicand; DIV: dividend shifting into quotient
  logic [WIDTH-1:0] opb_q;   // MUL: shifting multiplier;   DIV: divisor
  logic [WIDTH-1:0] acc_q;   // MUL: partial product;       DIV: partial remainder

  logic             is_iter;
  logic [WIDTH-1:0] quick_res;
  logic [WIDTH-1:0] step_a;
  logic [WIDTH-1:0] step_b;
  logic [WIDTH-1:0] step_acc;
  logic [WIDTH-1:0] iter_res;
`ifdef ALU_DIV_EN
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   diff;
`endif

  always_comb begin
    quick_res = '0;
    case (alu_op)
      OP_AND:  quick_res = src_a & src_b;
      OP_OR:   quick_res = src_a | src_b;
      OP_ADD:  quick_res = src_a + src_b;
      OP_SUB:  quick_res = src_a - src_b;
      OP_SLT:  quick_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: quick_res = '0;
    endcase
  end

  always_comb begin
`ifdef ALU_DIV_EN
    is_iter = (alu_op == OP_MUL) || (alu_op == OP_DIVU) || (alu_op == OP_REMU);
`else
    is_iter = (alu_op == OP_MUL);
`endif
  end

  always_comb begin
    step_a   = opa_q;
    step_b   = opb_q;
    step_acc = acc_q;
`ifdef ALU_DIV_EN
    rem_shift = '0;
    diff      = '0;
`endif
    if (op_q == OP_MUL) begin
      step_acc = acc_q + (opb_q[0] ? opa_q : '0);
      step_a   = opa_q << 1;
      step_b   = opb_q >> 1;
    end
`ifdef ALU_DIV_EN
    else begin
      // A zero divisor never borrows, giving an all-ones quotient and remainder = dividend.
      rem_shift = {acc_q, opa_q[WIDTH-1]};
      diff      = rem_shift - {1'b0, opb_q};
      if (!diff[WIDTH]) begin
        step_acc = diff[WIDTH-1:0];
        step_a   = {opa_q[WIDTH-2:0], 1'b1};
      end else begin
        step_acc = rem_shift[WIDTH-1:0];
        step_a   = {opa_q[WIDTH-2:0], 1'b0};
      end
    end
    iter_res = (op_q == OP_DIVU) ? step_a : step_acc;
`else
    iter_res = step_acc;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      op_q   <= '0;
      opa_q  <= '0;
      opb_q  <= '0;
      acc_q  <= '0;
      result <= '0;
      zero   <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (is_iter) begin
              state <= S_EXEC;
              op_q  <= alu_op;
              opa_q <= src_a;
              opb_q <= src_b;
              acc_q <= '0;
              cnt   <= CW'(WIDTH);
            end else begin
              state  <= S_DONE;
              result <= quick_res;
              zero   <= (quick_res == '0);
            end
          end
        end
        S_EXEC: begin
          opa_q <= step_a;
          opb_q <= step_b;
          acc_q <= step_acc;
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state  <= S_DONE;
            result <= iter_res;
            zero   <= (iter_res == '0);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign fsm_state = state;

endmodule

// File: tb/tb_iterative_alu_unit.sv
// Self-checking bench for iterative_alu_unit; covers the ALU_DIV_EN build when that
// macro is defined and the divider-less build otherwise.
module tb_iterative_alu_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   alu_op;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic [W-1:0] result;
  logic         zero;
  logic         busy;
  logic         done;
  logic [1:0]   fsm_state;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } vec_t;

  always #5 clk = ~clk;

  iterative_alu_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .alu_op(alu_op), .src_a(src_a), .src_b(src_b),
    .result(result), .zero(zero), .busy(busy), .done(done), .fsm_state(fsm_state)
  );

  function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1000: return a * b;
`ifdef ALU_DIV_EN
      4'b1001: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'b1010: return (b == 0) ? a : a % b;
`endif
      default: return '0;
    endcase
  endfunction

  // Driver: pulse start for one edge, push the expected result, then scramble operands.
  task automatic issue_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start  = 1'b1;
    alu_op = op;
    src_a  = a;
    src_b  = b;
    exp_q.push_back(model(op, a, b));
    @(negedge clk);
    start = 1'b0;
    src_a = $urandom;
    src_b = $urandom;
  endtask

  // Waits (bounded) for done; lat counts cycles after the start edge. Optionally pulses
  // an ADD start at cycle inject_at, which the busy unit must ignore.
  task automatic wait_done(input int inject_at, output int lat, output int busy_n);
    lat = 1;
    busy_n = 0;
    while (1) begin
      if (busy) busy_n++;
      if (done || lat >= 100) break;
      if (lat == inject_at) begin
        start = 1'b1; alu_op = 4'b0010; src_a = 32'd5; src_b = 32'd7;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; alu_op = '0; src_a = '0; src_b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (result !== '0 || zero !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || fsm_state !== 2'd0) begin
      errors++;
      $display("FAIL reset: result=%h zero=%b busy=%b done=%b state=%0d required 0/1/0/0/0",
               result, zero, busy, done, fsm_state);
    end
  endtask

  task automatic test_single();
    vec_t vq[$];
    logic [W-1:0] e;
    int lat, bn;
    vq.push_back({4'b0010, 32'd5, 32'd7});
    vq.push_back({4'b0110, 32'd3, 32'd3});
    vq.push_back({4'b0111, 32'hFFFF_FFFF, 32'd1});
    vq.push_back({4'b0111, 32'd1, 32'hFFFF_FFFF});
    vq.push_back({4'b0000, 32'hF0F0_1234, 32'hFF00_FF00});
    vq.push_back({4'b0001, 32'h0F0F_0000, 32'h0000_00F1});
    vq.push_back({4'b0010, 32'hFFFF_FFFF, 32'd2});
    vq.push_back({4'b0011, 32'd9, 32'd9});
    vq.push_back({4'b1111, 32'hAAAA_5555, 32'h1});
`ifndef ALU_DIV_EN
    vq.push_back({4'b1001, 32'd100, 32'd7});
    vq.push_back({4'b1010, 32'd100, 32'd7});
`endif
    for (int i = 0; i < 6; i++) begin
      logic [3:0] op;
      case ($urandom_range(0, 5))
        0: op = 4'b0000; 1: op = 4'b0001; 2: op = 4'b0010;
        3: op = 4'b0110; 4: op = 4'b0111; default: op = 4'b1101;
      endcase
      vq.push_back({op, 32'($urandom), 32'($urandom)});
    end
    foreach (vq[i]) begin
      issue_op(vq[i].op, vq[i].a, vq[i].b);
      wait_done(-1, lat, bn);
      e = exp_q.pop_front();
      checks++;
      if (done !== 1'b1 || lat != 1 || bn != 1 || result !== e || zero !== (e == '0)) begin
        errors++;
        $display("FAIL single op=%b a=%h b=%h: result=%h zero=%b lat=%0d busy=%0d required %h/%b/1/1",
                 vq[i].op, vq[i].a, vq[i].b, result, zero, lat, bn, e, (e == '0));
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL single_pulse: done=%b busy=%b required 0/0", done, busy);
      end
    end
  endtask

  task automatic test_mul();
    vec_t vq[$];
    logic [W-1:0] e;
    int lat, bn;
    vq.push_back({4'b1000, 32'h0000_FFFF, 32'h0001_0001});
    vq.push_back({4'b1000, 32'd0, 32'h1234_5678});
    vq.push_back({4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
    for (int i = 0; i < 3; i++) vq.push_back({4'b1000, 32'($urandom), 32'($urandom)});
    foreach (vq[i]) begin
      issue_op(vq[i].op, vq[i].a, vq[i].b);
      wait_done((i == 0) ? 10 : -1, lat, bn);
      e = exp_q.pop_front();
      checks++;
      if (done !== 1'b1 || lat != W + 1 || bn != W + 1 || result !== e || zero !== (e == '0)) begin
        errors++;
        $display("FAIL mul a=%h b=%h: result=%h zero=%b lat=%0d busy=%0d required %h/%b/%0d/%0d",
                 vq[i].a, vq[i].b, result, zero, lat, bn, e, (e == '0), W + 1, W + 1);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL mul_ignored_start: done=%b busy=%b required 0/0", done, busy);
      end
    end
  endtask

`ifdef ALU_DIV_EN
  task automatic test_div();
    vec_t vq[$];
    logic [W-1:0] e;
    int lat, bn;
    vq.push_back({4'b1001, 32'd100, 32'd7});
    vq.push_back({4'b1010, 32'd100, 32'd7});
    vq.push_back({4'b1001, 32'd9, 32'd0});
    vq.push_back({4'b1010, 32'd9, 32'd0});
    vq.push_back({4'b1001, 32'hFFFF_FFFF, 32'd1});
    vq.push_back({4'b1010, 32'd6, 32'd3});
    for (int i = 0; i < 4; i++)
      vq.push_back({(i % 2 == 0) ? 4'b1001 : 4'b1010, 32'($urandom), 32'($urandom_range(1, 70000))});
    foreach (vq[i]) begin
      issue_op(vq[i].op, vq[i].a, vq[i].b);
      wait_done(-1, lat, bn);
      e = exp_q.pop_front();
      checks++;
      if (done !== 1'b1 || lat != W + 1 || bn != W + 1 || result !== e || zero !== (e == '0)) begin
        errors++;
        $display("FAIL div op=%b a=%h b=%h: result=%h zero=%b lat=%0d busy=%0d required %h/%b/%0d",
                 vq[i].op, vq[i].a, vq[i].b, result, zero, lat, bn, e, (e == '0), W + 1);
      end
    end
  endtask
`endif

  task automatic test_abort();
    logic [W-1:0] e;
    int lat, bn;
    bit seen;
    issue_op(4'b1000, 32'h0000_FFFF, 32'h0001_0001);
    void'(exp_q.pop_back());
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL abort: busy=%b done=%b result=%h zero=%b required 0/0/0/1", busy, done, result, zero);
    end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL abort_quiet: activity seen=%b required 0", seen);
    end
    issue_op(4'b0010, 32'd1, 32'd1);
    wait_done(-1, lat, bn);
    e = exp_q.pop_front();
    checks++;
    if (done !== 1'b1 || lat != 1 || result !== e || result !== 32'd2) begin
      errors++;
      $display("FAIL abort_then_add: result=%h lat=%0d required %h/1", result, lat, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] e;
    int lat, bn;
    for (int i = 0; i < 5; i++) begin
      issue_op((i == 2) ? 4'b1000 : 4'b0010, 32'($urandom_range(0, 1000)), 32'($urandom_range(0, 1000)));
      wait_done(-1, lat, bn);
      e = exp_q.pop_front();
      checks++;
      if (done !== 1'b1 || result !== e || zero !== (e == '0)) begin
        errors++;
        $display("FAIL back_to_back[%0d]: result=%h zero=%b done=%b required %h/%b/1",
                 i, result, zero, done, e, (e == '0));
      end
      // A start offered during DONE must be dropped.
      start = 1'b1; alu_op = 4'b0001; src_a = 32'hDEAD_BEEF; src_b = '0;
    end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL done_start_ignored: busy=%b done=%b required 0/0", busy, done);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (result !== e || zero !== (e == '0)) begin
      errors++;
      $display("FAIL result_hold: result=%h zero=%b required %h/%b", result, zero, e, (e == '0));
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_mul();
`ifdef ALU_DIV_EN
    test_div();
`endif
    test_abort();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
